inv_mod_p: RTL and testbench



---
 rtl/sm2_pkg.sv | 14 +
 rtl/mod_sub_p.sv | 21 ++
 rtl/inv_mod_p.sv | 133 +++++++++++++
 tb/tb_inv_mod_p.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sm2_pkg.sv
// Shared SM2 field constants and the modular-inverse controller state encoding.
package sm2_pkg;

  localparam int SM2_WIDTH = 256;

  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  localparam logic [255:0] SM2_N =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;

  typedef enum logic [1:0] {IDLE, LOAD, STEP, FINISH} inv_state_t;

endpackage

// File: rtl/mod_sub_p.sv
// Combinational (x - y) mod P for x, y < P: a borrow out of the raw subtraction adds P back.
module mod_sub_p
  import sm2_pkg::*;
#(
  parameter int               WIDTH = SM2_WIDTH,
  parameter logic [WIDTH-1:0] P     = SM2_P
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH:0] diff;

  always_comb begin
    diff = {1'b0, x} - {1'b0, y};
    // Wrap-around of the low WIDTH bits makes diff + P land back in [0, P).
    r    = diff[WIDTH] ? (diff[WIDTH-1:0] + P) : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/inv_mod_p.sv
// Sequential modular inverse a^-1 mod P by binary extended Euclid, one step per clock.
// Optional step watchdog: define INV_MOD_P_WATCHDOG_EN.
module inv_mod_p
  import sm2_pkg::*;
#(
  parameter int               WIDTH = SM2_WIDTH,
  parameter logic [WIDTH-1:0] P     = SM2_P
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] inv,
  output logic             err
);

  inv_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, u_q, v_q, x1_q, x2_q, inv_q;
  logic             err_q;

  logic [WIDTH-1:0] a_red, sub12, sub21;
  logic             u_one, v_one, u_ge_v, wd_hit;

  // halve(x) = x/2 mod P; odd x is made even by adding the odd modulus first.
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  mod_sub_p #(.WIDTH(WIDTH), .P(P)) u_sub12 (.x(x1_q), .y(x2_q), .r(sub12));
  mod_sub_p #(.WIDTH(WIDTH), .P(P)) u_sub21 (.x(x2_q), .y(x1_q), .r(sub21));

  // One conditional subtraction reduces a because P > 2^(WIDTH-1).
  assign a_red  = (a_q >= P) ? (a_q - P) : a_q;
  assign u_one  = (u_q == WIDTH'(1));
  assign v_one  = (v_q == WIDTH'(1));
  assign u_ge_v = (u_q >= v_q);

`ifdef INV_MOD_P_WATCHDOG_EN
  logic [10:0] step_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
    end else if (state_q == LOAD) begin
      step_cnt_q <= '0;
    end else if (state_q == STEP) begin
      step_cnt_q <= step_cnt_q + 11'd1;
    end
  end

  assign wd_hit = (step_cnt_q == 11'(4 * WIDTH + 4));
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = (a_red == '0) ? FINISH : STEP;
      STEP:    if (u_one || v_one || wd_hit) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FINISH);
  end

  // Datapath: invariants x1*a == u and x2*a == v (mod P) hold after every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      u_q   <= '0;
      v_q   <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
      inv_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) a_q <= a;
        LOAD: begin
          u_q  <= a_red;
          v_q  <= P;
          x1_q <= WIDTH'(1);
          x2_q <= '0;
          if (a_red == '0) begin
            inv_q <= '0;
            err_q <= 1'b1;
          end
        end
        STEP: begin
          if (u_one || v_one) begin
            inv_q <= u_one ? x1_q : x2_q;
            err_q <= 1'b0;
          end else if (wd_hit) begin
            inv_q <= '0;
            err_q <= 1'b1;
          end else if (!u_q[0]) begin
            u_q  <= u_q >> 1;
            x1_q <= halve(x1_q);
          end else if (!v_q[0]) begin
            v_q  <= v_q >> 1;
            x2_q <= halve(x2_q);
          end else if (u_ge_v) begin
            u_q  <= u_q - v_q;
            x1_q <= sub12;
          end else begin
            v_q  <= v_q - u_q;
            x2_q <= sub21;
          end
        end
        default: ;
      endcase
    end
  end

  assign inv = inv_q;
  assign err = err_q;

endmodule

// File: tb/tb_inv_mod_p.sv
// Randomized self-checking bench for inv_mod_p against a Fermat-exponentiation reference.
module tb_inv_mod_p;
  import sm2_pkg::*;

  localparam int           W = SM2_WIDTH;
  localparam logic [255:0] P = SM2_P;
  localparam int           MAX_LAT = 4 * W + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] a = '0;
  logic         busy, done, err;
  logic [255:0] inv;

  int n_tests = 0;
  int n_fail  = 0;
  int inv_bad = 0;
  bit mon_en  = 1'b0;
  logic [255:0] a_ref = '0;

  inv_mod_p #(.WIDTH(W), .P(P)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .busy(busy), .done(done), .inv(inv), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] t;
    t = {256'b0, x} * {256'b0, y};
    t = t % {256'b0, P};
    return t[255:0];
  endfunction

  // Reference: a^(P-2) mod P (Fermat), after reducing a into [0, P).
  function automatic logic [255:0] ref_inv(input logic [255:0] x);
    logic [255:0] base, r, e;
    base = (x >= P) ? (x - P) : x;
    r    = 256'd1;
    e    = P - 256'd2;
    for (int i = 255; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, base);
    end
    return (base == '0) ? 256'd0 : r;
  endfunction

  function automatic logic [255:0] rnd_field();
    logic [255:0] x;
    do begin
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    end while (x == '0 || x >= P);
    return x;
  endfunction

  // Loop invariants observed inside the running algorithm.
  always @(negedge clk) begin
    if (mon_en && dut.state_q == STEP) begin
      if (dut.u_q >= P || dut.v_q > P || dut.x1_q >= P || dut.x2_q >= P)
        inv_bad++;
      else if (mulmod(dut.x1_q, a_ref) != dut.u_q ||
               mulmod(dut.x2_q, a_ref) != ((dut.v_q == P) ? 256'd0 : dut.v_q))
        inv_bad++;
    end
  end

  task automatic run_op(input logic [255:0] a_in, input bit b2b, input int intr_at,
                        input logic [255:0] a_intr, output logic [255:0] inv_o,
                        output logic err_o, output int cyc);
    int bad0;
    if (!b2b) @(negedge clk);
    a     = a_in;
    start = 1'b1;
    a_ref = (a_in >= P) ? (a_in - P) : a_in;
    bad0  = inv_bad;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = rnd_field();
    cyc   = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_after_start", 256'(busy), 256'd1);
      start = (cyc == intr_at);
      if (start) a = a_intr;
    end while (!done && cyc < MAX_LAT + 50);
    start = 1'b0;
    check("timeout", 256'(done), 256'd1);
    inv_o = inv;
    err_o = err;
    @(negedge clk);
    mon_en = 1'b0;
    check("done_width", 256'(done), 256'd0);
    check("busy_after_done", 256'(busy), 256'd0);
    check("invariants", 256'(inv_bad - bad0), 256'd0);
  endtask

  initial begin
    logic [255:0] r_inv, x, y, exp_two;
    logic         r_err;
    int           cyc, dn;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_inv", inv, 256'd0);
    check("rst_err", 256'(err), 256'd0);
    rst = 1'b0;

    run_op(256'd1, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("one_inv", r_inv, 256'd1);
    check("one_err", 256'(r_err), 256'd0);
    check("one_latency", 256'(cyc), 256'd3);

    exp_two = 256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_80000000_00000000;
    run_op(256'd2, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("two_inv", r_inv, exp_two);
    check("two_err", 256'(r_err), 256'd0);

    run_op(P - 256'd1, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("pm1_inv", r_inv, P - 256'd1);

    run_op(P + 256'd1, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("pp1_inv", r_inv, 256'd1);

    x = '1;
    run_op(x, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("allones_inv", r_inv, ref_inv(x));

    run_op(256'd0, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("zero_err", 256'(r_err), 256'd1);
    check("zero_inv", r_inv, 256'd0);
    check("zero_latency", 256'(cyc <= 3), 256'd1);

    run_op(P, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("p_err", 256'(r_err), 256'd1);
    check("p_inv", r_inv, 256'd0);
    check("p_latency", 256'(cyc <= 3), 256'd1);

    // Error flag must clear on the next good operation; start right after done.
    run_op(256'd3, 1'b1, -1, '0, r_inv, r_err, cyc);
    check("three_err", 256'(r_err), 256'd0);
    check("three_prod", mulmod(r_inv, 256'd3), 256'd1);

    for (int k = 0; k < 48; k++) begin
      x = rnd_field();
      run_op(x, k[0], -1, '0, r_inv, r_err, cyc);
      check("rand_inv", r_inv, ref_inv(x));
      check("rand_prod", mulmod(r_inv, x), 256'd1);
      check("rand_err", 256'(r_err), 256'd0);
      check("rand_latency", 256'(cyc <= MAX_LAT), 256'd1);
    end

    x = rnd_field();
    y = rnd_field();
    run_op(x, 1'b0, 20, y, r_inv, r_err, cyc);
    check("busy_start_ignored", r_inv, ref_inv(x));

    // Abort a running operation with reset.
    x = rnd_field();
    @(negedge clk);
    a = x;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("busy_before_abort", 256'(busy), 256'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 256'(busy), 256'd0);
    check("abort_done", 256'(done), 256'd0);
    check("abort_inv", inv, 256'd0);
    check("abort_err", 256'(err), 256'd0);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      dn += int'(done) + int'(busy);
    end
    check("abort_quiet", 256'(dn), 256'd0);

    x = rnd_field();
    run_op(x, 1'b0, -1, '0, r_inv, r_err, cyc);
    check("post_abort_inv", r_inv, ref_inv(x));
    check("post_abort_err", 256'(r_err), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
